// File: rtl/video_mnist_pkg.sv
// Shared constants and types for the MNIST argmax output stage.
// Class and vote-count widths here are the defaults used by video_mnist_argmax.
package video_mnist_pkg;

    localparam int CLASS_NUM     = 10;
    localparam int CHANNEL_NUM   = 8;
    localparam int CLASS_WIDTH   = 4;
    localparam int COUNT_WIDTH   = 4;
    localparam int S_TDATA_WIDTH = CLASS_NUM * CHANNEL_NUM;

    // Reported class index when the thresholded winner is too weak to be a digit.
    localparam int NONE_CLASS    = CLASS_NUM;

    typedef logic [CLASS_WIDTH-1:0] class_t;
    typedef logic [COUNT_WIDTH-1:0] count_t;

endpackage

// File: rtl/video_mnist_popcount.sv
// Combinational population count of one class's binary vote slice.
module video_mnist_popcount #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 4
) (
    input  logic [IN_WIDTH-1:0]  din,
    output logic [OUT_WIDTH-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            count = count + OUT_WIDTH'(din[i]);
        end
    end

endmodule

// File: rtl/video_mnist_argmax.sv
// Two-stage per-pixel argmax over the class vote vector (popcount, then argmax).
// Optional low-confidence "no digit" output enabled by VIDEO_MNIST_ARGMAX_THRESHOLD_EN.
module video_mnist_argmax
    import video_mnist_pkg::*;
#(
    parameter int TUSER_WIDTH   = 1,
    parameter int CLASS_NUM     = video_mnist_pkg::CLASS_NUM,
    parameter int CHANNEL_NUM   = video_mnist_pkg::CHANNEL_NUM,
    parameter int S_TDATA_WIDTH = CLASS_NUM * CHANNEL_NUM,
    parameter int CLASS_WIDTH   = video_mnist_pkg::CLASS_WIDTH,
    parameter int COUNT_WIDTH   = video_mnist_pkg::COUNT_WIDTH
) (
    input  logic                     aresetn,
    input  logic                     aclk,

    input  logic [TUSER_WIDTH-1:0]   s_axi4s_tuser,
    input  logic                     s_axi4s_tlast,
    input  logic [S_TDATA_WIDTH-1:0] s_axi4s_tdata,
    input  logic                     s_axi4s_tvalid,
    output logic                     s_axi4s_tready,

`ifdef VIDEO_MNIST_ARGMAX_THRESHOLD_EN
    input  logic [COUNT_WIDTH-1:0]   param_th,
`endif

    output logic [TUSER_WIDTH-1:0]   m_axi4s_tuser,
    output logic                     m_axi4s_tlast,
    output logic [CLASS_WIDTH-1:0]   m_axi4s_tclass,
    output logic [COUNT_WIDTH-1:0]   m_axi4s_tcount,
    output logic                     m_axi4s_tvalid,
    input  logic                     m_axi4s_tready
);

    generate
        if ((2 ** CLASS_WIDTH) <= CLASS_NUM) begin : g_bad_class_width
            $error("CLASS_WIDTH too small to encode CLASS_NUM and the no-digit index");
        end
        if ((2 ** COUNT_WIDTH) <= CHANNEL_NUM) begin : g_bad_count_width
            $error("COUNT_WIDTH too small to hold CHANNEL_NUM votes");
        end
        if (S_TDATA_WIDTH != CLASS_NUM * CHANNEL_NUM) begin : g_bad_tdata_width
            $error("S_TDATA_WIDTH must equal CLASS_NUM*CHANNEL_NUM");
        end
    endgenerate

    localparam logic [CLASS_WIDTH-1:0] NONE_IDX = CLASS_WIDTH'(CLASS_NUM);

    // Handshake: a beat moves on a rising aclk edge when valid and ready are both
    // high; valid never waits for ready, and a stalled master holds data stable.
    // The whole pipe advances together whenever the output register is empty or
    // being accepted, so input ready is that same enable with no skid storage.
    logic cke;

    assign cke            = ~m_axi4s_tvalid | m_axi4s_tready;
    assign s_axi4s_tready = cke;

    // ---------------------------------------------------------------- stage 1
    logic [CLASS_NUM-1:0][COUNT_WIDTH-1:0] pc_count;
    logic [CLASS_NUM-1:0][COUNT_WIDTH-1:0] st1_count;
    logic [TUSER_WIDTH-1:0]                st1_user;
    logic                                  st1_last;
    logic                                  st1_valid;

    generate
        for (genvar g = 0; g < CLASS_NUM; g++) begin : g_popcount
            video_mnist_popcount #(
                .IN_WIDTH  (CHANNEL_NUM),
                .OUT_WIDTH (COUNT_WIDTH)
            ) u_popcount (
                .din   (s_axi4s_tdata[g*CHANNEL_NUM +: CHANNEL_NUM]),
                .count (pc_count[g])
            );
        end
    endgenerate

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            st1_count <= '0;
            st1_user  <= '0;
            st1_last  <= 1'b0;
            st1_valid <= 1'b0;
        end else if (cke) begin
            st1_count <= pc_count;
            st1_user  <= s_axi4s_tuser;
            st1_last  <= s_axi4s_tlast;
            st1_valid <= s_axi4s_tvalid;
        end
    end

    // ---------------------------------------------------------------- argmax
    // Strict greater-than while scanning upward keeps the lowest index on ties.
    logic [CLASS_WIDTH-1:0] arg_class;
    logic [COUNT_WIDTH-1:0] arg_count;
    logic [CLASS_WIDTH-1:0] sel_class;

    always_comb begin
        arg_class = '0;
        arg_count = st1_count[0];
        for (int k = 1; k < CLASS_NUM; k++) begin
            if (st1_count[k] > arg_count) begin
                arg_class = CLASS_WIDTH'(k);
                arg_count = st1_count[k];
            end
        end
    end

`ifdef VIDEO_MNIST_ARGMAX_THRESHOLD_EN
    // A threshold of zero can never exceed an unsigned count, so it disables itself.
    assign sel_class = (arg_count < param_th) ? NONE_IDX : arg_class;
`else
    assign sel_class = arg_class;
`endif

    // ---------------------------------------------------------------- stage 2
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axi4s_tclass <= '0;
            m_axi4s_tcount <= '0;
            m_axi4s_tuser  <= '0;
            m_axi4s_tlast  <= 1'b0;
            m_axi4s_tvalid <= 1'b0;
        end else if (cke) begin
            m_axi4s_tclass <= sel_class;
            m_axi4s_tcount <= arg_count;
            m_axi4s_tuser  <= st1_user;
            m_axi4s_tlast  <= st1_last;
            m_axi4s_tvalid <= st1_valid;
        end
    end

endmodule

// File: tb/tb_video_mnist_argmax.sv
// Self-checking bench for video_mnist_argmax: directed vectors plus a scoreboard.
// Threshold scenario is compiled in with VIDEO_MNIST_ARGMAX_THRESHOLD_EN.
module tb_video_mnist_argmax;

    localparam int DW = 80;
    localparam int EW = 10; // {tuser, tlast, tclass[3:0], tcount[3:0]}

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [0:0]    s_tuser = '0;
    logic          s_tlast = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [0:0]    m_tuser;
    logic          m_tlast;
    logic [3:0]    m_tclass;
    logic [3:0]    m_tcount;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic [3:0]    th_tb = 4'd0;

    int checks = 0;
    int failures = 0;
    int out_count = 0;
    logic [EW-1:0] exp_q[$];

    bit bp_en = 1'b0;
    bit frame_mode = 1'b0;
    int frame_idx = 0;
    int frame_user = 0;
    int frame_last = 0;

    video_mnist_argmax dut (
        .aresetn        (aresetn),
        .aclk           (aclk),
        .s_axi4s_tuser  (s_tuser),
        .s_axi4s_tlast  (s_tlast),
        .s_axi4s_tdata  (s_tdata),
        .s_axi4s_tvalid (s_tvalid),
        .s_axi4s_tready (s_tready),
`ifdef VIDEO_MNIST_ARGMAX_THRESHOLD_EN
        .param_th       (th_tb),
`endif
        .m_axi4s_tuser  (m_tuser),
        .m_axi4s_tlast  (m_tlast),
        .m_axi4s_tclass (m_tclass),
        .m_axi4s_tcount (m_tcount),
        .m_axi4s_tvalid (m_tvalid),
        .m_axi4s_tready (m_tready)
    );

    // ------------------------------------------------------ clock / reset
    always #5 aclk = ~aclk;

    // ------------------------------------------------------ reference model
    function automatic logic [EW-1:0] model(input logic [DW-1:0] d, input logic u,
                                            input logic l, input logic [3:0] th);
        int best;
        int idx;
        int c;
        best = 0;
        idx  = 0;
        for (int k = 0; k < 10; k++) begin
            c = 0;
            for (int j = 0; j < 8; j++) c += int'(d[k*8+j]);
            if (c > best) begin
                best = c;
                idx  = k;
            end
        end
`ifdef VIDEO_MNIST_ARGMAX_THRESHOLD_EN
        if (best < int'(th)) idx = 10;
`endif
        return {u, l, 4'(idx), 4'(best)};
    endfunction

    function automatic logic [DW-1:0] mk(input int hot, input logic [7:0] hv,
                                         input logic [7:0] other);
        logic [DW-1:0] d;
        for (int k = 0; k < 10; k++) d[k*8 +: 8] = (k == hot) ? hv : other;
        return d;
    endfunction

    // ------------------------------------------------------ scoreboard / monitor
    initial begin : monitor
        logic [EW-1:0] got;
        logic [EW-1:0] hold;
        logic [EW-1:0] exp;
        bit hold_valid;
        hold_valid = 1'b0;
        hold = '0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                hold_valid = 1'b0;
            end else begin
                got = {m_tuser, m_tlast, m_tclass, m_tcount};
                if (m_tvalid && m_tready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL out_unexpected got=%h required=none", got);
                    end else begin
                        exp = exp_q.pop_front();
                        if (got !== exp) begin
                            failures++;
                            $display("FAIL out_beat got=%h required=%h", got, exp);
                        end
                    end
                    if (frame_mode) begin
                        if (m_tuser[0]) frame_user++;
                        if (m_tlast) begin
                            frame_last++;
                            checks++;
                            if ((frame_idx % 28) != 27) begin
                                failures++;
                                $display("FAIL frame_tlast_pos got=%0d required=27 mod 28", frame_idx);
                            end
                        end
                        frame_idx++;
                    end
                    out_count++;
                end
                if (m_tvalid && !m_tready) begin
                    if (hold_valid) begin
                        checks++;
                        if (got !== hold) begin
                            failures++;
                            $display("FAIL stall_stable got=%h required=%h", got, hold);
                        end
                    end
                    hold = got;
                    hold_valid = 1'b1;
                end else begin
                    hold_valid = 1'b0;
                end
                if (s_tvalid && s_tready) exp_q.push_back(model(s_tdata, s_tuser[0], s_tlast, th_tb));
            end
        end
    end

    initial begin : ready_driver
        forever begin
            @(posedge aclk);
            #1;
            if (bp_en) m_tready = 1'($urandom_range(0, 1));
        end
    end

    // ------------------------------------------------------ driver tasks
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic u, input logic l);
        bit acc;
        int n;
        s_tdata  = d;
        s_tuser  = u;
        s_tlast  = l;
        s_tvalid = 1'b1;
        n = 0;
        acc = 1'b0;
        do begin
            @(negedge aclk);
            acc = s_tready;
            tick();
            n++;
        end while (!acc && n < 200);
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout got=not_accepted required=accepted");
        end
        s_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n;
        bp_en = 1'b0;
        m_tready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout got=%0d pending required=0", exp_q.size());
        end
    endtask

    // ------------------------------------------------------ tests
    task automatic test_reset();
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        checks += 6;
        if (m_tvalid !== 1'b0) begin failures++; $display("FAIL rst_tvalid got=%b required=0", m_tvalid); end
        if (m_tclass !== 4'd0) begin failures++; $display("FAIL rst_tclass got=%0d required=0", m_tclass); end
        if (m_tcount !== 4'd0) begin failures++; $display("FAIL rst_tcount got=%0d required=0", m_tcount); end
        if (m_tuser !== 1'b0)  begin failures++; $display("FAIL rst_tuser got=%b required=0", m_tuser); end
        if (m_tlast !== 1'b0)  begin failures++; $display("FAIL rst_tlast got=%b required=0", m_tlast); end
        if (s_tready !== 1'b1) begin failures++; $display("FAIL rst_tready got=%b required=1", s_tready); end
        @(negedge aclk);
        aresetn = 1'b1;
        tick();
    endtask

    task automatic test_single();
        m_tready = 1'b1;
        send_beat(mk(3, 8'hFF, 8'h01), 1'b0, 1'b0);
        @(negedge aclk);
        checks++;
        if (m_tvalid !== 1'b0) begin failures++; $display("FAIL single_early got=%b required=0", m_tvalid); end
        @(negedge aclk);
        checks += 3;
        if (m_tvalid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b required=1", m_tvalid); end
        if (m_tclass !== 4'd3) begin failures++; $display("FAIL single_class got=%0d required=3", m_tclass); end
        if (m_tcount !== 4'd8) begin failures++; $display("FAIL single_count got=%0d required=8", m_tcount); end
        @(negedge aclk);
        checks++;
        if (m_tvalid !== 1'b0) begin failures++; $display("FAIL single_once got=%b required=0", m_tvalid); end
        drain();
    endtask

    task automatic test_tie();
        logic [DW-1:0] d;
        d = '0;
        d[2*8 +: 8] = 8'h0F;
        d[7*8 +: 8] = 8'h0F;
        send_beat(d, 1'b0, 1'b0);
        @(negedge aclk);
        @(negedge aclk);
        checks += 3;
        if (m_tvalid !== 1'b1) begin failures++; $display("FAIL tie_valid got=%b required=1", m_tvalid); end
        if (m_tclass !== 4'd2) begin failures++; $display("FAIL tie_class got=%0d required=2", m_tclass); end
        if (m_tcount !== 4'd4) begin failures++; $display("FAIL tie_count got=%0d required=4", m_tcount); end
        drain();
        // All-zero vector and a winner in the last class.
        send_beat('0, 1'b0, 1'b0);
        @(negedge aclk);
        @(negedge aclk);
        checks += 2;
        if (m_tclass !== 4'd0) begin failures++; $display("FAIL zero_class got=%0d required=0", m_tclass); end
        if (m_tcount !== 4'd0) begin failures++; $display("FAIL zero_count got=%0d required=0", m_tcount); end
        drain();
        send_beat(mk(9, 8'h07, 8'h03), 1'b0, 1'b0);
        @(negedge aclk);
        @(negedge aclk);
        checks += 2;
        if (m_tclass !== 4'd9) begin failures++; $display("FAIL top_class got=%0d required=9", m_tclass); end
        if (m_tcount !== 4'd3) begin failures++; $display("FAIL top_count got=%0d required=3", m_tcount); end
        drain();
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] d;
        bp_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            for (int w = 0; w < 3; w++) d[w*32 +: 32] = $urandom();
            if ($urandom_range(0, 3) == 0) tick();
            send_beat(d[DW-1:0], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain();
    endtask

    task automatic test_frame();
        logic [DW-1:0] d;
        frame_mode = 1'b1;
        frame_idx  = 0;
        frame_user = 0;
        frame_last = 0;
        m_tready   = 1'b1;
        for (int i = 0; i < 784; i++) begin
            for (int w = 0; w < 3; w++) d[w*32 +: 32] = $urandom();
            send_beat(d[DW-1:0], i == 0, (i % 28) == 27);
        end
        drain();
        frame_mode = 1'b0;
        checks += 3;
        if (frame_idx != 784) begin failures++; $display("FAIL frame_beats got=%0d required=784", frame_idx); end
        if (frame_user != 1)  begin failures++; $display("FAIL frame_tuser got=%0d required=1", frame_user); end
        if (frame_last != 28) begin failures++; $display("FAIL frame_tlast got=%0d required=28", frame_last); end
    endtask

    task automatic test_reset_midstream();
        int base;
        m_tready = 1'b1;
        s_tdata = mk(9, 8'hFF, 8'h00); s_tuser = 1'b1; s_tlast = 1'b1; s_tvalid = 1'b1;
        tick();
        s_tdata = mk(1, 8'hFF, 8'h00); s_tuser = 1'b0; s_tlast = 1'b1;
        tick();
        s_tvalid = 1'b0;
        aresetn  = 1'b0;
        exp_q.delete();
        #1;
        checks += 5;
        if (m_tvalid !== 1'b0) begin failures++; $display("FAIL midrst_tvalid got=%b required=0", m_tvalid); end
        if (m_tclass !== 4'd0) begin failures++; $display("FAIL midrst_tclass got=%0d required=0", m_tclass); end
        if (m_tcount !== 4'd0) begin failures++; $display("FAIL midrst_tcount got=%0d required=0", m_tcount); end
        if (m_tuser !== 1'b0)  begin failures++; $display("FAIL midrst_tuser got=%b required=0", m_tuser); end
        if (m_tlast !== 1'b0)  begin failures++; $display("FAIL midrst_tlast got=%b required=0", m_tlast); end
        @(negedge aclk);
        aresetn = 1'b1;
        tick();
        base = out_count;
        send_beat(mk(5, 8'hFF, 8'h00), 1'b0, 1'b0);
        @(negedge aclk);
        checks++;
        if (m_tvalid !== 1'b0) begin failures++; $display("FAIL midrst_stale got=%b required=0", m_tvalid); end
        @(negedge aclk);
        checks += 3;
        if (m_tvalid !== 1'b1) begin failures++; $display("FAIL midrst_valid got=%b required=1", m_tvalid); end
        if (m_tclass !== 4'd5) begin failures++; $display("FAIL midrst_class got=%0d required=5", m_tclass); end
        if (m_tcount !== 4'd8) begin failures++; $display("FAIL midrst_count got=%0d required=8", m_tcount); end
        drain();
        checks++;
        if (out_count != base + 1) begin
            failures++;
            $display("FAIL midrst_beats got=%0d required=%0d", out_count - base, 1);
        end
    endtask

`ifdef VIDEO_MNIST_ARGMAX_THRESHOLD_EN
    task automatic test_threshold();
        th_tb = 4'd5;
        send_beat(mk(4, 8'h0F, 8'h00), 1'b0, 1'b0);
        @(negedge aclk);
        @(negedge aclk);
        checks += 2;
        if (m_tclass !== 4'd10) begin failures++; $display("FAIL th_low_class got=%0d required=10", m_tclass); end
        if (m_tcount !== 4'd4)  begin failures++; $display("FAIL th_low_count got=%0d required=4", m_tcount); end
        drain();
        send_beat(mk(6, 8'h3F, 8'h01), 1'b0, 1'b0);
        @(negedge aclk);
        @(negedge aclk);
        checks += 2;
        if (m_tclass !== 4'd6) begin failures++; $display("FAIL th_high_class got=%0d required=6", m_tclass); end
        if (m_tcount !== 4'd6) begin failures++; $display("FAIL th_high_count got=%0d required=6", m_tcount); end
        drain();
        th_tb = 4'd0;
        send_beat(mk(4, 8'h0F, 8'h00), 1'b0, 1'b0);
        @(negedge aclk);
        @(negedge aclk);
        checks++;
        if (m_tclass !== 4'd4) begin failures++; $display("FAIL th_off_class got=%0d required=4", m_tclass); end
        drain();
    endtask
`endif

    // ------------------------------------------------------ sequence / report
    initial begin
        test_reset();
        test_single();
        test_tie();
        test_backpressure();
        test_frame();
        test_reset_midstream();
`ifdef VIDEO_MNIST_ARGMAX_THRESHOLD_EN
        test_threshold();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
